// File: rtl/rv_isa_pkg.sv
// RV64 ISA constants shared by the instruction encoder and the immediate benches:
// major opcodes, the encoder's format selector and the immediate range limits.
package rv_isa_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {
        FMT_LOAD   = 2'b00,
        FMT_STORE  = 2'b01,
        FMT_BRANCH = 2'b10,
        FMT_OPIMM  = 2'b11
    } fmt_e;

    // Signed byte-offset limits; branches additionally need an even offset.
    localparam int signed IMM_IS_MIN = -2048;
    localparam int signed IMM_IS_MAX = 2047;
    localparam int signed IMM_B_MIN  = -4096;
    localparam int signed IMM_B_MAX  = 4094;

    function automatic logic [6:0] fmt_opcode(input fmt_e fmt);
        logic [6:0] opc;
        unique case (fmt)
            FMT_LOAD:   opc = OPC_LOAD;
            FMT_STORE:  opc = OPC_STORE;
            FMT_BRANCH: opc = OPC_BRANCH;
            default:    opc = OPC_OPIMM;
        endcase
        return opc;
    endfunction

    // I-type formats place rd in [11:7]; S/B place immediate bits there instead.
    function automatic logic fmt_has_rd(input fmt_e fmt);
        return (fmt == FMT_LOAD) || (fmt == FMT_OPIMM);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters a signed immediate into its I/S/B bit positions of a 32-bit word
// (all other bits zero) and flags values the chosen format cannot represent.
module imm_pack
    import rv_isa_pkg::*;
#(
    parameter int unsigned xlen = 64
) (
    input  fmt_e                   fmt_i,
    input  logic signed [xlen-1:0] imm_i,
    output logic        [31:0]     imm_bits_o,
    output logic                   err_o
);

    // Limits widened to the full datapath so the compare sees every upper bit.
    localparam logic signed [xlen-1:0] LIM_IS_MIN = xlen'(IMM_IS_MIN);
    localparam logic signed [xlen-1:0] LIM_IS_MAX = xlen'(IMM_IS_MAX);
    localparam logic signed [xlen-1:0] LIM_B_MIN  = xlen'(IMM_B_MIN);
    localparam logic signed [xlen-1:0] LIM_B_MAX  = xlen'(IMM_B_MAX);

    logic is_range_bad;
    logic b_range_bad;

    // Range checks are computed for both families; the format picks one.
    always_comb begin
        is_range_bad = (imm_i < LIM_IS_MIN) || (imm_i > LIM_IS_MAX);
        b_range_bad  = (imm_i < LIM_B_MIN) || (imm_i > LIM_B_MAX) || imm_i[0];
    end

    // Bit scatter per format; out-of-range values still pack their low bits.
    always_comb begin
        imm_bits_o = '0;
        err_o      = 1'b0;
        unique case (fmt_i)
            FMT_STORE: begin
                imm_bits_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
                err_o      = is_range_bad;
            end
            FMT_BRANCH: begin
                imm_bits_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
                err_o      = b_range_bad;
            end
            default: begin
                imm_bits_o = {imm_i[11:0], 20'b0};
                err_o      = is_range_bad;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV64 instruction encoder for the program-loader path. Stage 1
// captures the decoded fields with the packed immediate and its range flag;
// stage 2 holds the assembled word for the downstream handshake. Words leave
// at an auto-incrementing address; range violations are flagged, never dropped.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int unsigned     xlen      = 64,
    parameter logic [xlen-1:0] base_addr = '0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_fmt,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [2:0]             in_funct3,
    input  logic signed [xlen-1:0] in_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [xlen-1:0]        out_addr,
    output logic                   out_err,
    output logic [15:0]            out_count
);

    // Stage 1 registers
    logic            s1_vld_q,  s1_vld_d;
    fmt_e            s1_fmt_q,  s1_fmt_d;
    logic [4:0]      s1_rd_q,   s1_rd_d;
    logic [4:0]      s1_rs1_q,  s1_rs1_d;
    logic [4:0]      s1_rs2_q,  s1_rs2_d;
    logic [2:0]      s1_f3_q,   s1_f3_d;
    logic [31:0]     s1_imm_q,  s1_imm_d;
    logic            s1_err_q,  s1_err_d;

    // Stage 2 registers and the output bookkeeping
    logic            s2_vld_q,   s2_vld_d;
    logic [31:0]     s2_instr_q, s2_instr_d;
    logic            s2_err_q,   s2_err_d;
    logic [xlen-1:0] addr_q,     addr_d;
    logic [15:0]     count_q,    count_d;

    fmt_e            in_fmt_e;
    logic [31:0]     pack_bits;
    logic            pack_err;
    logic            out_fire;
    logic            s2_load;
    logic            s1_adv;
    logic            in_fire;
    logic [31:0]     asm_word;

    assign in_fmt_e = fmt_e'(in_fmt);

    imm_pack #(
        .xlen (xlen)
    ) u_imm_pack (
        .fmt_i      (in_fmt_e),
        .imm_i      (in_imm),
        .imm_bits_o (pack_bits),
        .err_o      (pack_err)
    );

    // Handshake: S2 frees when empty or accepted; S1 frees when empty or moving on.
    always_comb begin
        out_fire = s2_vld_q && out_ready;
        s2_load  = !s2_vld_q || out_ready;
        s1_adv   = s1_vld_q && s2_load;
        in_ready = !s1_vld_q || s1_adv;
        in_fire  = in_valid && in_ready;
    end

    // Word assembly from the stage 1 fields; rd only exists in I-type words.
    always_comb begin
        asm_word        = s1_imm_q;
        asm_word[19:15] = s1_rs1_q;
        asm_word[14:12] = s1_f3_q;
        asm_word[6:0]   = fmt_opcode(s1_fmt_q);
        if (fmt_has_rd(s1_fmt_q)) begin
            asm_word[11:7] = s1_rd_q;
        end else begin
            asm_word[24:20] = s1_rs2_q;
        end
    end

    // Next-state selection; clear overrides every handshake in the same cycle.
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_fmt_d   = s1_fmt_q;
        s1_rd_d    = s1_rd_q;
        s1_rs1_d   = s1_rs1_q;
        s1_rs2_d   = s1_rs2_q;
        s1_f3_d    = s1_f3_q;
        s1_imm_d   = s1_imm_q;
        s1_err_d   = s1_err_q;
        s2_vld_d   = s2_vld_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        addr_d     = addr_q;
        count_d    = count_q;

        if (clear) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
            addr_d   = base_addr;
            count_d  = '0;
        end else begin
            if (in_ready) begin
                s1_vld_d = in_valid;
            end
            if (in_fire) begin
                s1_fmt_d = in_fmt_e;
                s1_rd_d  = in_rd;
                s1_rs1_d = in_rs1;
                s1_rs2_d = in_rs2;
                s1_f3_d  = in_funct3;
                s1_imm_d = pack_bits;
                s1_err_d = pack_err;
            end
            if (s2_load) begin
                s2_vld_d = s1_vld_q;
            end
            if (s1_adv) begin
                s2_instr_d = asm_word;
                s2_err_d   = s1_err_q;
            end
            if (out_fire) begin
                addr_d  = addr_q + xlen'(4);
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end
        end
    end

    // State registers; reset drops every in-flight word and rewinds the address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q   <= 1'b0;
            s1_fmt_q   <= FMT_LOAD;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_f3_q    <= '0;
            s1_imm_q   <= '0;
            s1_err_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            addr_q     <= base_addr;
            count_q    <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_rd_q    <= s1_rd_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s1_f3_q    <= s1_f3_d;
            s1_imm_q   <= s1_imm_d;
            s1_err_q   <= s1_err_d;
            s2_vld_q   <= s2_vld_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign out_addr  = addr_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, stalls, clear, mid-stream reset,
// randomized traffic and counter saturation, against a field-level reference.
module tb_instr_encoder;

    localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFF0;

    logic               clk;
    logic               rstn;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_fmt;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [2:0]         in_funct3;
    logic signed [63:0] in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [63:0]        out_addr;
    logic               out_err;
    logic [15:0]        out_count;

    instr_encoder #(
        .xlen      (64),
        .base_addr (BASE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [63:0] maddr;
    int          mcount;
    logic [31:0] nxt_instr;
    logic        nxt_err;
    logic        accepted;
    logic        held_v;
    logic [31:0] held_instr;
    logic [63:0] held_addr;
    logic        held_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from field values with plain integer arithmetic.
    function automatic logic [31:0] model_word(input int fmt, input int rd, input int rs1,
                                               input int rs2, input int f3, input longint imm);
        longint w;
        longint opc;
        longint lo;
        opc = (fmt == 0) ? 3 : (fmt == 1) ? 35 : (fmt == 2) ? 99 : 19;
        w   = opc + (longint'(rs1) << 15) + (longint'(f3) << 12);
        if (fmt == 0 || fmt == 3) begin
            lo = imm & 4095;
            w  = w + (lo << 20) + (longint'(rd) << 7);
        end else if (fmt == 1) begin
            lo = imm & 4095;
            w  = w + ((lo >> 5) << 25) + (longint'(rs2) << 20) + ((lo & 31) << 7);
        end else begin
            lo = imm & 8191;
            w  = w + (((lo >> 12) & 1) << 31) + (((lo >> 5) & 63) << 25)
                   + (longint'(rs2) << 20) + (((lo >> 1) & 15) << 8) + (((lo >> 11) & 1) << 7);
        end
        return 32'(w);
    endfunction

    function automatic logic model_err(input int fmt, input longint imm);
        if (fmt == 2) return (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
        return (imm < -2048) || (imm > 2047);
    endfunction

    task automatic set_fields(input int fmt, input int rd, input int rs1, input int rs2,
                              input int f3, input longint imm);
        in_fmt    = 2'(fmt);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_imm    = imm;
        nxt_instr = model_word(fmt, rd, rs1, rs2, f3, imm);
        nxt_err   = model_err(fmt, imm);
    endtask

    task automatic rand_fields();
        longint imm;
        longint edges[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097, 4093};
        case ($urandom_range(0, 3))
            0: imm = edges[$urandom_range(0, 9)];
            1: imm = longint'($urandom_range(0, 10000)) - 5000;
            2: imm = (longint'($urandom_range(0, 8191)) - 4096) & ~longint'(1);
            default: imm = {$urandom, $urandom};
        endcase
        set_fields($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 7), imm);
    endtask

    task automatic flush_model();
        q.delete();
        maddr  = BASE;
        mcount = 0;
        held_v = 1'b0;
    endtask

    // One clock: observe at the falling edge, update the model, return after the rise.
    task automatic step();
        logic exp_ov;
        exp_t e;
        @(negedge clk);
        cyc++;
        accepted = 1'b0;
        exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
        chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("out_count", 64'(out_count), 64'(mcount));
        if (held_v) begin
            chk("stall_instr", 64'(out_instr), 64'(held_instr));
            chk("stall_addr", out_addr, held_addr);
            chk("stall_err", 64'(out_err), 64'(held_err));
        end
        held_v     = out_valid && !out_ready && !clear;
        held_instr = out_instr;
        held_addr  = out_addr;
        held_err   = out_err;
        if (out_valid && out_ready && !clear && q.size() > 0) begin
            e = q.pop_front();
            chk("out_instr", 64'(out_instr), 64'(e.instr));
            chk("out_err", 64'(out_err), 64'(e.err));
            chk("out_addr", out_addr, maddr);
            maddr  = maddr + 64'd4;
            mcount = (mcount == 65535) ? mcount : mcount + 1;
        end
        if (in_valid && in_ready && !clear) begin
            e.instr = nxt_instr;
            e.err   = nxt_err;
            e.cyc   = cyc;
            q.push_back(e);
            accepted = 1'b1;
        end
        if (clear) flush_model();
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        int n = 0;
        in_valid = 1'b1;
        accepted = 1'b0;
        while (!accepted && n < 40) begin
            step();
            n++;
        end
        chk("accept_timeout", 64'(accepted), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0);
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_out_count", 64'(out_count), 64'(0));
        rstn = 1'b1;
        step();

        // Directed vectors at full rate
        out_ready = 1'b1;
        set_fields(2, 0, 1, 2, 0, 40);     nxt_instr = 32'h02208463; nxt_err = 1'b0; send();
        set_fields(2, 0, 5, 6, 0, -8);     nxt_instr = 32'hfe628ce3; nxt_err = 1'b0; send();
        set_fields(0, 2, 2, 0, 3, 34);     nxt_instr = 32'h02213103; nxt_err = 1'b0; send();
        set_fields(1, 0, 5, 6, 3, -300);   nxt_instr = 32'hec62ba23; nxt_err = 1'b0; send();
        set_fields(2, 0, 3, 4, 1, 41);     nxt_err = 1'b1; send();
        set_fields(0, 7, 8, 0, 2, 2048);   nxt_err = 1'b1; send();
        drain();
        chk("count_after_directed", 64'(out_count), 64'(6));

        // Stall: three words with the output blocked
        out_ready = 1'b0;
        rand_fields(); send();
        rand_fields(); send();
        rand_fields(); in_valid = 1'b1;
        step();
        chk("in_ready_full", 64'(in_ready), 64'(0));
        step();
        out_ready = 1'b1;
        send();
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            rand_fields();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        // Clear with the pipeline full, then with one word and a live input
        out_ready = 1'b0;
        rand_fields(); send();
        rand_fields(); send();
        in_valid = 1'b1; clear = 1'b1; rand_fields();
        step();
        clear = 1'b0; in_valid = 1'b0;
        step();
        chk("clr_out_addr", out_addr, BASE);
        chk("clr_out_valid", 64'(out_valid), 64'(0));
        rand_fields(); send();
        in_valid = 1'b1; clear = 1'b1; rand_fields();
        step();
        clear = 1'b0; in_valid = 1'b0;
        step();
        step();
        chk("clr2_out_valid", 64'(out_valid), 64'(0));
        set_fields(0, 2, 2, 0, 3, 34); send();
        drain();

        // Reset asserted mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_fields(); send();
        end
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_addr", out_addr, BASE);
        chk("mid_rst_out_count", 64'(out_count), 64'(0));
        flush_model();
        step();
        step();
        rstn = 1'b1;
        set_fields(2, 0, 1, 2, 0, 40); send();
        drain();

        // Counter saturation under continuous traffic
        out_ready = 1'b1;
        set_fields(3, 1, 1, 0, 0, 5);
        in_valid = 1'b1;
        for (int i = 0; i < 65545; i++) step();
        drain();
        chk("count_saturated", 64'(out_count), 64'(16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
